// File: rtl/spi_rom_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_rom_responder_pkg                                            |
// | Brief   : Opcodes, state encoding and shifter helpers for the SPI ROM      |
// |           responder.                                                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package spi_rom_responder_pkg;

    localparam logic [7:0]  c_cmd_read  = 8'h03;
    localparam logic [7:0]  c_cmd_qread = 8'h6B;
    localparam int unsigned c_spi_aw    = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    // Serial mode places its single bit on io[1]; quad mode sends the high nibble.
    function automatic logic [3:0] lead_bits(input logic quad, input logic [7:0] b);
        return quad ? b[7:4] : {2'b00, b[7], 1'b0};
    endfunction

    function automatic logic [7:0] shift_on(input logic quad, input logic [7:0] b);
        return quad ? {b[3:0], 4'h0} : {b[6:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_sync_edge                                                    |
// | Brief   : Two-flop synchronizer with rise/fall pulses on the synced level. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spi_sync_edge (
    input  logic clk,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Left unreset so the synced level is trustworthy the moment reset releases.
    always_ff @(posedge clk) begin
        r_meta <= i_async;
        r_sync <= r_meta;
        r_prev <= r_sync;
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_rom_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spi_rom_responder                                                |
// | Brief   : SPI ROM target serving Read (0x03) and Quad Output Fast Read     |
// |           (0x6B) from a synchronous memory port, oversampled in clk.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spi_rom_responder
    import spi_rom_responder_pkg::*;
#(
    parameter int MEM_AW     = 18,
    parameter int DUMMY_CLKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic [3:0]        spi_io_in,
    output logic [3:0]        spi_io_out,
    output logic [3:0]        spi_io_oe,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              bad_cmd
);

    localparam logic [4:0] c_last_cmd_bit  = 5'd7;
    localparam logic [4:0] c_last_addr_bit = 5'd23;
    localparam logic [4:0] c_last_dummy    = 5'(DUMMY_CLKS - 1);
    localparam logic [3:0] c_oe_serial     = 4'b0010;
    localparam logic [3:0] c_oe_quad       = 4'b1111;

    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic [3:0] r_io_meta;
    logic [3:0] r_io_s;

    state_t r_state;
    state_t w_state_nxt;

    logic [4:0]          r_bit_cnt;
    logic [6:0]          r_cmd_sr;
    logic [22:0]         r_addr_sr;
    logic [c_spi_aw-1:0] r_addr;
    logic                r_is_quad;
    logic [7:0]          r_hold;
    logic [7:0]          r_shift;
    logic [2:0]          r_phase;
    logic                r_rd_d;
    logic [3:0]          r_io_out;
    logic [3:0]          r_io_oe;
    logic                r_mem_rd;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic                r_busy;
    logic                r_bad_cmd;

    logic [7:0]          w_opcode;
    logic                w_cmd_ok;
    logic [c_spi_aw-1:0] w_addr_full;
    logic [7:0]          w_src_byte;
    logic                w_byte_last;
    logic                w_unused;

    spi_sync_edge u_sync_cs (
        .clk     (clk),
        .i_async (spi_cs_n),
        .o_sync  (w_cs_s),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_sync_edge u_sync_sclk (
        .clk     (clk),
        .i_async (spi_sclk),
        .o_sync  (w_sclk_s),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // Same two-flop depth as SCLK, so io is aligned with the detected rise.
    always_ff @(posedge clk) begin
        r_io_meta <= spi_io_in;
        r_io_s    <= r_io_meta;
    end

    assign w_opcode    = {r_cmd_sr, r_io_s[0]};
    assign w_cmd_ok    = (w_opcode == c_cmd_read) || (w_opcode == c_cmd_qread);
    assign w_addr_full = {r_addr_sr, r_io_s[0]};
    // Phase 0 starts a fresh byte, which always comes from the prefetched holding register.
    assign w_src_byte  = (r_phase == 3'd0) ? r_hold : r_shift;
    assign w_byte_last = r_is_quad ? (r_phase == 3'd1) : (r_phase == 3'd7);
    assign w_unused    = ^{w_sclk_s, r_io_s[3:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // CS already low without a seen fall (e.g. after reset): sit out this transaction.
                    if (w_cs_fall) begin
                        w_state_nxt = ST_CMD;
                    end else if (!w_cs_s) begin
                        w_state_nxt = ST_IGNORE;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise && (r_bit_cnt == c_last_cmd_bit)) begin
                        w_state_nxt = w_cmd_ok ? ST_ADDR : ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (w_sclk_rise && (r_bit_cnt == c_last_addr_bit)) begin
                        w_state_nxt = r_is_quad ? ST_DUMMY : ST_DATA;
                    end
                end
                ST_DUMMY: begin
                    if (w_sclk_rise && (r_bit_cnt == c_last_dummy)) begin
                        w_state_nxt = ST_DATA;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_out   <= '0;
            r_io_oe    <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_bad_cmd  <= 1'b0;
            r_rd_d     <= 1'b0;
            r_hold     <= '0;
            r_shift    <= '0;
            r_phase    <= '0;
            r_bit_cnt  <= '0;
            r_cmd_sr   <= '0;
            r_addr_sr  <= '0;
            r_addr     <= '0;
            r_is_quad  <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            r_rd_d   <= r_mem_rd;
            if (r_rd_d) begin
                r_hold <= mem_data;
            end
            if (w_cs_rise) begin
                r_io_out <= '0;
                r_io_oe  <= '0;
                r_busy   <= 1'b0;
                r_rd_d   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_busy    <= 1'b1;
                            r_bad_cmd <= 1'b0;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_cmd_sr <= w_opcode[6:0];
                            if (r_bit_cnt == c_last_cmd_bit) begin
                                r_bit_cnt <= '0;
                                r_is_quad <= (w_opcode == c_cmd_qread);
                                if (!w_cmd_ok) begin
                                    r_bad_cmd <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr_sr <= w_addr_full[22:0];
                            if (r_bit_cnt == c_last_addr_bit) begin
                                // First read goes out now; it lands in the holding register before the first fall.
                                r_bit_cnt  <= '0;
                                r_phase    <= '0;
                                r_mem_rd   <= 1'b1;
                                r_mem_addr <= w_addr_full[MEM_AW-1:0];
                                r_addr     <= w_addr_full + 24'd1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    ST_DATA: begin
                        if (w_sclk_fall) begin
                            r_io_out <= lead_bits(r_is_quad, w_src_byte);
                            r_shift  <= shift_on(r_is_quad, w_src_byte);
                            r_io_oe  <= r_is_quad ? c_oe_quad : c_oe_serial;
                            r_phase  <= w_byte_last ? 3'd0 : r_phase + 3'd1;
                            if (r_phase == 3'd0) begin
                                r_mem_rd   <= 1'b1;
                                r_mem_addr <= r_addr[MEM_AW-1:0];
                                r_addr     <= r_addr + 24'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign spi_io_out = r_io_out;
    assign spi_io_oe  = r_io_oe;
    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign busy       = r_busy;
    assign bad_cmd    = r_bad_cmd;

endmodule
`default_nettype wire

// File: tb/tb_spi_rom_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spi_rom_responder                                             |
// | Brief   : Directed self-checking bench for spi_rom_responder.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spi_rom_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic [3:0]  spi_io_in = 4'h0;
    logic [3:0]  spi_io_out;
    logic [3:0]  spi_io_oe;
    logic        mem_rd;
    logic [17:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        busy;
    logic        bad_cmd;

    int checks = 0;
    int failures = 0;
    logic [17:0] log_q[$];

    logic [3:0]  o_s, e_s, oe_or;
    logic [31:0] data;
    int          bad_oe;

    always #5 clk = ~clk;

    spi_rom_responder #(.MEM_AW(18), .DUMMY_CLKS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_io_in  (spi_io_in),
        .spi_io_out (spi_io_out),
        .spi_io_oe  (spi_io_oe),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .bad_cmd    (bad_cmd)
    );

    function automatic logic [7:0] mem_model(input logic [17:0] a);
        case (a)
            18'h00100: return 8'h3C;
            18'h00101: return 8'hF0;
            18'h00102: return 8'h81;
            default:   return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Data only valid the cycle after a strobe; otherwise a marker value.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= mem_model(mem_addr);
            log_q.push_back(mem_addr);
        end else begin
            mem_data <= 8'hEE;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_cycle(input logic [3:0] drv, output logic [3:0] out_s, output logic [3:0] oe_s);
        spi_sclk  = 1'b0;
        spi_io_in = drv;
        repeat (4) @(negedge clk);
        out_s = spi_io_out;
        oe_s  = spi_io_oe;
        spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n, output logic [3:0] oe_acc);
        logic [3:0] o, e;
        oe_acc = 4'h0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_cycle({3'b000, val[i]}, o, e);
            oe_acc |= e;
        end
    endtask

    task automatic read_serial(input int nbits, output logic [31:0] d, output int bad);
        logic [3:0] o, e;
        d = '0;
        bad = 0;
        for (int i = 0; i < nbits; i++) begin
            spi_cycle(4'h0, o, e);
            d = {d[30:0], o[1]};
            if (e !== 4'b0010) bad++;
        end
    endtask

    task automatic read_quad(input int nnib, output logic [31:0] d, output int bad);
        logic [3:0] o, e;
        d = '0;
        bad = 0;
        for (int i = 0; i < nnib; i++) begin
            spi_cycle(4'h0, o, e);
            d = {d[27:0], o};
            if (e !== 4'b1111) bad++;
        end
    endtask

    task automatic spi_start();
        spi_sclk = 1'b0;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_stop();
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check("rst_io_out", spi_io_out, 0);
        check("rst_io_oe", spi_io_oe, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_bad_cmd", bad_cmd, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Read 0x03 at 0x000010, 4 bytes
        log_q.delete();
        spi_start();
        check("t1_busy", busy, 1);
        send_bits(32'h03, 8, oe_or);
        send_bits(32'h000010, 24, e_s);
        oe_or |= e_s;
        check("t1_oe_pre_data", oe_or, 0);
        read_serial(32, data, bad_oe);
        check("t1_data", data, 32'hB5B4B7B6);
        check("t1_oe_data", bad_oe, 0);
        spi_stop();
        check("t1_busy_end", busy, 0);
        check("t1_oe_end", spi_io_oe, 0);
        check("t1_rd_count", log_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("t1_rd_addr", (i < log_q.size()) ? log_q[i] : 18'h3DEAD, 18'h10 + i);
        end

        // Quad read 0x6B at 0x000100, 8 dummy, 3 bytes
        log_q.delete();
        spi_start();
        send_bits(32'h6B, 8, oe_or);
        send_bits(32'h000100, 24, e_s);
        oe_or |= e_s;
        send_bits(32'h0, 8, e_s);
        oe_or |= e_s;
        check("t2_oe_pre_data", oe_or, 0);
        read_quad(6, data, bad_oe);
        check("t2_data", data, 32'h003CF081);
        check("t2_oe_data", bad_oe, 0);
        spi_stop();
        check("t2_rd_count", log_q.size(), 4);
        check("t2_rd_first", (log_q.size() > 0) ? log_q[0] : 18'h3DEAD, 18'h100);

        // Bad opcode then 32 SCLKs
        log_q.delete();
        spi_start();
        send_bits(32'h9F, 8, oe_or);
        check("t3_bad_set", bad_cmd, 1);
        send_bits(32'hFFFF_FFFF, 32, e_s);
        oe_or |= e_s;
        check("t3_oe", oe_or, 0);
        check("t3_rd_count", log_q.size(), 0);
        spi_stop();
        check("t3_bad_sticky", bad_cmd, 1);
        spi_start();
        check("t3_bad_clear", bad_cmd, 0);
        send_bits(32'h03, 8, oe_or);
        send_bits(32'h000005, 24, oe_or);
        read_serial(8, data, bad_oe);
        check("t3_next_data", data, 32'hA0);
        check("t3_next_bad", bad_cmd, 0);
        spi_stop();

        // Abort after 3 data bits, then read 0x000020
        spi_start();
        send_bits(32'h03, 8, oe_or);
        send_bits(32'h000030, 24, oe_or);
        read_serial(3, data, bad_oe);
        check("t4_partial", data, 32'h4);
        check("t4_oe_before", spi_io_oe, 4'b0010);
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_oe_abort", spi_io_oe, 0);
        check("t4_busy_abort", busy, 0);
        @(negedge clk);
        spi_sclk = 1'b0;
        repeat (6) @(negedge clk);
        spi_start();
        send_bits(32'h03, 8, oe_or);
        send_bits(32'h000020, 24, oe_or);
        read_serial(8, data, bad_oe);
        check("t4_after_data", data, 32'h85);
        spi_stop();

        // Address wrap at 0xFFFFFF
        log_q.delete();
        spi_start();
        send_bits(32'h03, 8, oe_or);
        send_bits(32'hFFFFFF, 24, oe_or);
        read_serial(16, data, bad_oe);
        check("t5_data", data, 32'h5AA5);
        spi_stop();
        check("t5_rd_count", log_q.size(), 3);
        check("t5_addr0", (log_q.size() > 0) ? log_q[0] : 18'h1DEAD, 18'h3FFFF);
        check("t5_addr1", (log_q.size() > 1) ? log_q[1] : 18'h1DEAD, 18'h00000);

        // Reset mid-DATA with CS held low
        spi_start();
        send_bits(32'h03, 8, oe_or);
        send_bits(32'h000040, 24, oe_or);
        read_serial(4, data, bad_oe);
        check("t6_oe_before", spi_io_oe, 4'b0010);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_outs", {spi_io_out, spi_io_oe, mem_rd, busy, bad_cmd}, 0);
        check("t6_rst_addr", mem_addr, 0);
        reset = 1'b0;
        log_q.delete();
        send_bits(32'h0300_0041, 32, oe_or);
        check("t6_ignore_oe", oe_or, 0);
        check("t6_ignore_rd", log_q.size(), 0);
        check("t6_ignore_bad", bad_cmd, 0);
        check("t6_ignore_busy", busy, 0);
        spi_stop();
        spi_start();
        send_bits(32'h03, 8, oe_or);
        send_bits(32'h000041, 24, oe_or);
        read_serial(8, data, bad_oe);
        check("t6_next_data", data, 32'hE4);
        check("t6_next_oe", bad_oe, 0);
        spi_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
